// File: rtl/latch_bank_write_ctrl_pkg.sv
// latch_bank_write_ctrl_pkg: shared state encoding and width helper for the latch bank write controller
package latch_bank_write_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, GATE = 2'd2, HOLD = 2'd3} state_t;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/latch_bank_write_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; pointer state lives in the parent
module rr_arbiter
    import latch_bank_write_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx
);
    logic found;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int o = 0; o < N_REQ; o++) begin
            if (!found && req[(int'(ptr) + o) % N_REQ]) begin
                found = 1'b1;
                idx   = PW'((int'(ptr) + o) % N_REQ);
            end
        end
        if (found) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/latch_bank_write_ctrl.sv
// latch_bank_write_ctrl: arbitrates writes onto a gated-latch bank with setup/gate/hold sequencing
module latch_bank_write_ctrl
    import latch_bank_write_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int N_LATCH   = 4,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int AW        = clog2_min1(N_LATCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       latch_d,
    output logic [N_LATCH-1:0]     latch_g,
    output logic                   busy
);
    localparam int PW   = clog2_min1(N_REQ);
    localparam int MAXC = (SETUP_CYC > GATE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                 : ((GATE_CYC > HOLD_CYC) ? GATE_CYC : HOLD_CYC);
    localparam int CW   = clog2_min1(MAXC + 1);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [AW-1:0]        addr_q;
    logic [N_REQ-1:0]     win_oh, grant;
    logic [PW-1:0]        ptr, win_idx;
    logic [N_LATCH-1:0]   g_n;
    logic                 cap, last;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last    = (cnt == '0);
        cap     = (state == IDLE) && (|req);
        unique case (state)
            IDLE:  if (cap) begin state_n = SETUP; cnt_n = CW'(SETUP_CYC - 1); end
            SETUP: if (last) begin state_n = GATE; cnt_n = CW'(GATE_CYC - 1); end else cnt_n = cnt - CW'(1);
            GATE:  if (last) begin state_n = HOLD; cnt_n = CW'(HOLD_CYC - 1); end else cnt_n = cnt - CW'(1);
            HOLD:  if (last) state_n = IDLE; else cnt_n = cnt - CW'(1);
        endcase
        // out-of-range addresses match no bit, so the sequence runs with no gate
        g_n = '0;
        for (int i = 0; i < N_LATCH; i++) g_n[i] = (state_n == GATE) && (addr_q == AW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            win_oh  <= '0;
            ptr     <= '0;
            latch_d <= '0;
            latch_g <= '0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (cap) begin
                addr_q  <= req_addr[int'(win_idx)*AW +: AW];
                latch_d <= req_data[int'(win_idx)*WIDTH +: WIDTH];
                win_oh  <= grant;
                ptr     <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
            end
            latch_g <= g_n;
            ack     <= (state_n == HOLD && cnt_n == '0) ? win_oh : '0;
            busy    <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// tb_latch_bank_write_ctrl: directed checks of the latch bank write controller against a latch model
module tb_latch_bank_write_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [7:0]  latch_d;
    logic [3:0]  latch_g;
    logic        busy;
    logic [3:0]  req3 = '0;
    logic [7:0]  req_addr3 = '0;
    logic [31:0] req_data3 = '0;
    logic [3:0]  ack3;
    logic [7:0]  d3;
    logic [2:0]  g3;
    logic        busy3;
    logic [31:0] memv;
    logic [23:0] memv3;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pd = '0, pd3 = '0;
    logic [3:0]  pg = '0;
    logic [2:0]  pg3 = '0;

    always #5 clk = ~clk;

    latch_bank_write_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .latch_d(latch_d), .latch_g(latch_g), .busy(busy)
    );

    latch_bank_write_ctrl #(.N_LATCH(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_addr(req_addr3), .req_data(req_data3),
        .ack(ack3), .latch_d(d3), .latch_g(g3), .busy(busy3)
    );

    for (genvar k = 0; k < 4; k++) begin : g_lat
        logic [7:0] q;
        always_latch if (latch_g[k]) q <= latch_d;
        assign memv[k*8 +: 8] = q;
    end

    for (genvar k = 0; k < 3; k++) begin : g_lat3
        logic [7:0] q;
        always_latch if (g3[k]) q <= d3;
        assign memv3[k*8 +: 8] = q;
    end

    // reset clears D and G together, so that cycle is excluded from the D-vs-G rule
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(latch_g) > 1 || $countones(g3) > 1 ||
                (latch_d !== pd && (latch_g != 0 || pg != 0)) ||
                (d3 !== pd3 && (g3 != 0 || pg3 != 0))) begin
                errors++;
                $display("FAIL stability: g=%b d=%h prev_g=%b prev_d=%h g3=%b d3=%h prev_g3=%b prev_d3=%h",
                         latch_g, latch_d, pg, pd, g3, d3, pg3, pd3);
            end
        end
        pd  <= latch_d;
        pg  <= latch_g;
        pd3 <= d3;
        pg3 <= g3;
    end

    task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
        req_addr[i*2 +: 2] = a;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (latch_g !== 4'b0)  begin errors++; $display("FAIL reset_g: got %b want 0000", latch_g); end
        checks++; if (ack !== 4'b0)      begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (latch_d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h want 00", latch_d); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int n, cyc, tp;
        logic [3:0] exp_ack;
        n = 0; cyc = 0; tp = 0;
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h10 + 8'(i));
        req = 4'hF;
        while (n < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack != 0) begin
                exp_ack = 4'b0001 << (n % 4);
                checks++;
                if (ack !== exp_ack) begin errors++; $display("FAIL contention_order[%0d]: got %b want %b", n, ack, exp_ack); end
                if (n > 0) begin
                    checks++;
                    if (cyc - tp != 5) begin errors++; $display("FAIL contention_gap[%0d]: got %0d want 5", n, cyc - tp); end
                end
                tp = cyc;
                n++;
                if (n == 5) req = '0;
            end
        end
        checks++;
        if (n != 5) begin errors++; req = '0; $display("FAIL contention_timeout: got %0d acks want 5", n); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (memv[i*8 +: 8] !== 8'h10 + 8'(i))
                begin errors++; $display("FAIL contention_mem[%0d]: got %h want %h", i, memv[i*8 +: 8], 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_single();
        logic [3:0] eg [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] ea [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        set_req(0, 2'd2, 8'hA5);
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (latch_g !== eg[c] || ack !== ea[c] || busy !== eb[c] || latch_d !== 8'hA5) begin
                errors++;
                $display("FAIL single[%0d]: got g=%b ack=%b busy=%b d=%h want g=%b ack=%b busy=%b d=a5",
                         c, latch_g, ack, busy, latch_d, eg[c], ea[c], eb[c]);
            end
            if (c == 3) req = '0;
        end
        checks++;
        if (memv[16 +: 8] !== 8'hA5) begin errors++; $display("FAIL single_mem: got %h want a5", memv[16 +: 8]); end
    endtask

    task automatic test_bad_addr();
        int cyc;
        logic gseen;
        logic [3:0] aseen;
        req_addr3[1:0] = 2'd1;
        req_data3[7:0] = 8'h3C;
        req3 = 4'b0001;
        cyc = 0;
        while (ack3 == 0 && cyc < 10) begin @(negedge clk); cyc++; end
        req3 = '0;
        checks++;
        if (ack3 !== 4'b0001) begin errors++; $display("FAIL bad_prewrite_ack: got %b want 0001", ack3); end
        repeat (2) @(negedge clk);
        req_addr3[3:2] = 2'd3;
        req_data3[15:8] = 8'hFF;
        req3 = 4'b0010;
        gseen = 1'b0;
        aseen = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (g3 != 0) gseen = 1'b1;
            if (ack3 != 0) begin aseen = ack3; req3 = '0; end
        end
        checks++; if (gseen !== 1'b0)       begin errors++; $display("FAIL bad_gate: got gate activity want none"); end
        checks++; if (aseen !== 4'b0010)    begin errors++; $display("FAIL bad_ack: got %b want 0010", aseen); end
        checks++; if (memv3[15:8] !== 8'h3C) begin errors++; $display("FAIL bad_mem: got %h want 3c", memv3[15:8]); end
        checks++; if (d3 !== 8'hFF)         begin errors++; $display("FAIL bad_d: got %h want ff", d3); end
    endtask

    task automatic test_reset_mid_gate();
        int cyc;
        set_req(1, 2'd1, 8'h5A);
        req = 4'b0010;
        repeat (2) @(negedge clk);
        checks++;
        if (latch_g !== 4'b0010) begin errors++; $display("FAIL midgate_pre: got %b want 0010", latch_g); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (latch_g !== 4'b0 || busy !== 1'b0 || ack !== 4'b0)
            begin errors++; $display("FAIL midgate_reset: got g=%b busy=%b ack=%b want 0000/0/0000", latch_g, busy, ack); end
        req = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        set_req(0, 2'd0, 8'h66);
        set_req(3, 2'd3, 8'h99);
        req = 4'b1001;
        cyc = 0;
        while (ack == 0 && cyc < 10) begin @(negedge clk); cyc++; end
        req = '0;
        checks++;
        if (ack !== 4'b0001) begin errors++; $display("FAIL midgate_first_grant: got %b want 0001", ack); end
        repeat (2) @(negedge clk);
        checks++;
        if (memv[7:0] !== 8'h66) begin errors++; $display("FAIL midgate_mem: got %h want 66", memv[7:0]); end
    endtask

    task automatic test_req_drop();
        int cyc;
        set_req(1, 2'd3, 8'hC3);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        cyc = 0;
        while (ack == 0 && cyc < 8) begin @(negedge clk); cyc++; end
        checks++;
        if (ack !== 4'b0010) begin errors++; $display("FAIL drop_ack: got %b want 0010", ack); end
        set_req(2, 2'd0, 8'h77);
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_gap: got busy=%b want 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL drop_restart: got busy=%b want 1", busy); end
        cyc = 0;
        while (ack == 0 && cyc < 8) begin @(negedge clk); cyc++; end
        req = '0;
        checks++;
        if (ack !== 4'b0100) begin errors++; $display("FAIL drop_next_ack: got %b want 0100", ack); end
        repeat (2) @(negedge clk);
        checks++;
        if (memv[31:24] !== 8'hC3 || memv[7:0] !== 8'h77)
            begin errors++; $display("FAIL drop_mem: got w3=%h w0=%h want c3/77", memv[31:24], memv[7:0]); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_bad_addr();
        test_reset_mid_gate();
        test_req_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
